// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: posts stores into a small write buffer and drains it to a
// variable-latency bus; loads wait for the buffer to empty and then stall until data returns.
module mem_stage_ctrl #(
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_DONE} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               bus_req_reg, bus_req_next;
  logic               bus_we_reg, bus_we_next;
  logic [31:0]        bus_addr_reg, bus_addr_next;
  logic [31:0]        bus_wdata_reg, bus_wdata_next;
  logic [31:0]        read_data_reg, read_data_next;
  logic               full, enq, deq;

  // Buffer storage is not reset: clearing the count is what discards pending stores.
  logic [29:0]        wb_addr_mem [WB_DEPTH];
  logic [31:0]        wb_data_mem [WB_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count_reg == CNT_W'(WB_DEPTH));
  // A simultaneous load+store is illegal; the load wins and the store is dropped.
  assign enq  = MemWriteM & ~MemReadM & ~full;

  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr_mem[tail_reg] <= ALUOutM[31:2];
      wb_data_mem[tail_reg] <= WriteDataM;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    read_data_next = read_data_reg;
    deq            = 1'b0;
    case (state_reg)
      IDLE: begin
        // Draining always goes first so a load never overtakes an older store.
        if (count_reg != '0) begin
          state_next     = WR_BUSY;
          bus_req_next   = 1'b1;
          bus_we_next    = 1'b1;
          bus_addr_next  = {wb_addr_mem[head_reg], 2'b00};
          bus_wdata_next = wb_data_mem[head_reg];
        end else if (MemReadM) begin
          state_next    = RD_BUSY;
          bus_req_next  = 1'b1;
          bus_we_next   = 1'b0;
          bus_addr_next = {ALUOutM[31:2], 2'b00};
        end
      end
      WR_BUSY: begin
        if (bus_ack) begin
          deq          = 1'b1;
          state_next   = IDLE;
          bus_req_next = 1'b0;
        end
      end
      RD_BUSY: begin
        if (bus_ack) begin
          read_data_next = bus_rdata;
          state_next     = RD_DONE;
          bus_req_next   = 1'b0;
        end
      end
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Stall is forced low while reset is held so the hazard unit releases immediately.
  always_comb begin
    MemStallM = 1'b0;
    if (!reset)
      MemStallM = 1'b0;
    else if (MemReadM)
      MemStallM = (state_reg != RD_DONE);
    else if (MemWriteM)
      MemStallM = full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      read_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      read_data_reg <= read_data_next;
      if (enq) tail_reg <= ptr_inc(tail_reg);
      if (deq) head_reg <= ptr_inc(head_reg);
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign ReadDataM = read_data_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change just after each falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        MemStallM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks   = 0;
  int failures = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WB_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemStallM(MemStallM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always @(posedge clk) begin
    if (reset && bus_req && bus_ack)
      $display("bus %s addr=%h wdata=%h rdata=%h", bus_we ? "WR" : "RD", bus_addr, bus_wdata, bus_rdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemReadM = rd; MemWriteM = wr; ALUOutM = a; WriteDataM = d;
  endtask

  initial begin
    reset = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    drive(1'b0, 1'b0, '0, '0);
    cyc(); cyc(); #1;
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_we", {31'b0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_stall", {31'b0, MemStallM}, 32'd0);
    cyc(); reset = 1'b1;

    // Store then drain, ack one cycle after request
    cyc(); drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); #1;
    chk("st1_stall", {31'b0, MemStallM}, 32'd0);
    cyc(); drive(1'b0, 1'b0, '0, '0); #1;
    chk("st1_req_lo", {31'b0, bus_req}, 32'd0);
    cyc(); #1;
    chk("st1_req", {31'b0, bus_req}, 32'd1);
    chk("st1_we", {31'b0, bus_we}, 32'd1);
    chk("st1_addr", bus_addr, 32'h10);
    chk("st1_wdata", bus_wdata, 32'hDEADBEEF);
    cyc(); bus_ack = 1'b1; #1;
    chk("st1_req_hold", {31'b0, bus_req}, 32'd1);
    chk("st1_addr_hold", bus_addr, 32'h10);
    cyc(); bus_ack = 1'b0; #1;
    chk("st1_req_drop", {31'b0, bus_req}, 32'd0);
    cyc(); #1;
    chk("st1_empty", {31'b0, bus_req}, 32'd0);

    // Buffer full: third store stalls until the first ack
    cyc(); drive(1'b0, 1'b1, 32'h100, 32'h11111111); #1;
    chk("full_s1_stall", {31'b0, MemStallM}, 32'd0);
    cyc(); drive(1'b0, 1'b1, 32'h104, 32'h22222222); #1;
    chk("full_s2_stall", {31'b0, MemStallM}, 32'd0);
    cyc(); drive(1'b0, 1'b1, 32'h108, 32'h33333333); #1;
    chk("full_s3_stall", {31'b0, MemStallM}, 32'd1);
    chk("full_w1_addr", bus_addr, 32'h100);
    chk("full_w1_req", {31'b0, bus_req}, 32'd1);
    cyc(); bus_ack = 1'b1; #1;
    chk("full_s3_stall2", {31'b0, MemStallM}, 32'd1);
    chk("full_w1_data", bus_wdata, 32'h11111111);
    cyc(); bus_ack = 1'b0; #1;
    chk("full_s3_go", {31'b0, MemStallM}, 32'd0);
    chk("full_gap", {31'b0, bus_req}, 32'd0);
    cyc(); drive(1'b0, 1'b0, '0, '0); bus_ack = 1'b1; #1;
    chk("full_w2_addr", bus_addr, 32'h104);
    chk("full_w2_data", bus_wdata, 32'h22222222);
    cyc(); bus_ack = 1'b0; #1;
    chk("full_gap2", {31'b0, bus_req}, 32'd0);
    cyc(); bus_ack = 1'b1; #1;
    chk("full_w3_req", {31'b0, bus_req}, 32'd1);
    chk("full_w3_addr", bus_addr, 32'h108);
    chk("full_w3_data", bus_wdata, 32'h33333333);
    cyc(); bus_ack = 1'b0; #1;
    chk("full_done", {31'b0, bus_req}, 32'd0);

    // Load after two stores: read issued only after both writes complete
    cyc(); drive(1'b0, 1'b1, 32'h20, 32'hAAAA0020); #1;
    cyc(); drive(1'b0, 1'b1, 32'h24, 32'hBBBB0024); #1;
    chk("ld_st2_stall", {31'b0, MemStallM}, 32'd0);
    cyc(); drive(1'b1, 1'b0, 32'h24, '0); #1;
    chk("ld_stall_w1", {31'b0, MemStallM}, 32'd1);
    chk("ld_w1_addr", bus_addr, 32'h20);
    chk("ld_w1_we", {31'b0, bus_we}, 32'd1);
    cyc(); bus_ack = 1'b1; #1;
    cyc(); bus_ack = 1'b0; #1;
    chk("ld_stall_gap", {31'b0, MemStallM}, 32'd1);
    chk("ld_gap_req", {31'b0, bus_req}, 32'd0);
    cyc(); bus_ack = 1'b1; #1;
    chk("ld_w2_addr", bus_addr, 32'h24);
    chk("ld_w2_we", {31'b0, bus_we}, 32'd1);
    chk("ld_stall_w2", {31'b0, MemStallM}, 32'd1);
    cyc(); bus_ack = 1'b0; #1;
    chk("ld_gap2_req", {31'b0, bus_req}, 32'd0);
    chk("ld_stall_gap2", {31'b0, MemStallM}, 32'd1);
    cyc(); bus_ack = 1'b1; bus_rdata = 32'h12345678; #1;
    chk("ld_rd_req", {31'b0, bus_req}, 32'd1);
    chk("ld_rd_we", {31'b0, bus_we}, 32'd0);
    chk("ld_rd_addr", bus_addr, 32'h24);
    cyc(); bus_ack = 1'b0; bus_rdata = '0; #1;
    chk("ld_done_stall", {31'b0, MemStallM}, 32'd0);
    chk("ld_done_data", ReadDataM, 32'h12345678);
    cyc(); drive(1'b0, 1'b0, '0, '0); #1;
    chk("ld_hold_data", ReadDataM, 32'h12345678);
    chk("ld_no_reissue", {31'b0, bus_req}, 32'd0);

    // Unaligned best-case load: exactly two stall cycles
    stall_cycles = 0;
    cyc(); drive(1'b1, 1'b0, 32'h33, '0); #1;
    if (MemStallM) stall_cycles++;
    cyc(); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
    if (MemStallM) stall_cycles++;
    chk("ua_addr", bus_addr, 32'h30);
    cyc(); bus_ack = 1'b0; #1;
    if (MemStallM) stall_cycles++;
    chk("ua_data", ReadDataM, 32'hCAFEF00D);
    chk("ua_stalls", stall_cycles, 32'd2);
    cyc(); drive(1'b0, 1'b0, '0, '0); #1;

    // Spurious ack while idle
    cyc(); bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; #1;
    cyc(); #1;
    chk("sp_req", {31'b0, bus_req}, 32'd0);
    chk("sp_data", ReadDataM, 32'hCAFEF00D);
    cyc(); bus_ack = 1'b0; #1;
    chk("sp_req2", {31'b0, bus_req}, 32'd0);
    chk("sp_stall", {31'b0, MemStallM}, 32'd0);

    // Reset in the middle of a read
    cyc(); drive(1'b1, 1'b0, 32'h40, '0); #1;
    cyc(); #1;
    chk("rr_req", {31'b0, bus_req}, 32'd1);
    reset = 1'b0; #1;
    chk("rr_req_lo", {31'b0, bus_req}, 32'd0);
    chk("rr_stall", {31'b0, MemStallM}, 32'd0);
    chk("rr_data", ReadDataM, 32'd0);
    chk("rr_addr", bus_addr, 32'd0);
    cyc(); drive(1'b0, 1'b0, '0, '0); reset = 1'b1;
    cyc(); #1;
    chk("rr_no_reissue", {31'b0, bus_req}, 32'd0);
    cyc(); #1;
    chk("rr_no_reissue2", {31'b0, bus_req}, 32'd0);

    // Reset while draining discards pending stores
    cyc(); drive(1'b0, 1'b1, 32'h50, 32'h55555550); #1;
    cyc(); drive(1'b0, 1'b1, 32'h54, 32'h55555554); #1;
    cyc(); drive(1'b0, 1'b0, '0, '0); #1;
    chk("rw_req", {31'b0, bus_req}, 32'd1);
    reset = 1'b0; #1;
    chk("rw_req_lo", {31'b0, bus_req}, 32'd0);
    chk("rw_wdata", bus_wdata, 32'd0);
    cyc(); reset = 1'b1;
    cyc(); #1;
    cyc(); #1;
    chk("rw_empty", {31'b0, bus_req}, 32'd0);
    cyc(); #1;
    chk("rw_empty2", {31'b0, bus_req}, 32'd0);

    // Illegal read+write: load serviced, store dropped
    cyc(); drive(1'b1, 1'b1, 32'h60, 32'h00000066); #1;
    $display("note: illegal MemReadM+MemWriteM presented at addr %h", ALUOutM);
    chk("il_stall", {31'b0, MemStallM}, 32'd1);
    cyc(); bus_ack = 1'b1; bus_rdata = 32'h0BADCAFE; #1;
    chk("il_we", {31'b0, bus_we}, 32'd0);
    chk("il_addr", bus_addr, 32'h60);
    cyc(); bus_ack = 1'b0; #1;
    chk("il_data", ReadDataM, 32'h0BADCAFE);
    cyc(); drive(1'b0, 1'b0, '0, '0); #1;
    cyc(); #1;
    chk("il_dropped", {31'b0, bus_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
